// File: rtl/rv32_pkg.sv
// Shared RV32I front-end types: fetch packet layout and ISA width constants.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- canonical bubble for downstream stages.
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Packet handed to the IF/ID pipe register.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

    // Instruction fetch is word granular; low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count. Data type is a
// parameter so the same block buffers both request addresses and packets.
// The head reads as all-zero while the FIFO is empty.
import rv32_pkg::*;

module fetch_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          flush,
    input  logic          push,
    input  T              wr_data,
    input  logic          pop,
    output T              rd_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !flush && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_data = empty ? T'('0) : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (sync_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care outside the valid window.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Producers are credit-limited, so dropping a push means accounting broke.
    a_no_overflow: assert property (@(posedge clk) disable iff (sync_rst)
        !(push && full && !pop && !flush));

    // Popping an empty FIFO means a response arrived with nothing outstanding.
    a_no_underflow: assert property (@(posedge clk) disable iff (sync_rst)
        !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to imem under a
// credit limit, pairs responses with their addresses and presents {pc, instr}
// packets to the IF/ID register over valid/ready. Redirects discard responses
// to requests issued before the redirect.
import rv32_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2              // legal 1..4
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        out_valid,
    output fetch_pkt_t  out_pkt,
    input  logic        out_ready
);

    localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0]   MAX_C = (CW + 1)'(MAX_OUTSTANDING);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   addr_count;
    logic [XLEN-1:0] rsp_addr;
    logic            credit;
    logic            accept;
    logic            rsp_live;
    logic            rsp_push;
    logic            rsp_pop;
    fetch_pkt_t      rsp_pkt;

    // Buffered packets count against credit too, so the response FIFO can
    // never be asked to hold more than it has room for.
    assign credit    = ({1'b0, inflight} + {1'b0, fifo_count}) < MAX_C;
    assign req_valid = !sync_rst && !redirect_valid && credit;
    assign req_addr  = pc;
    assign accept    = req_valid && req_ready;

    assign rsp_live  = rsp_valid && (drop == '0);
    assign rsp_push  = rsp_live && !redirect_valid;
    assign rsp_pop   = out_valid && out_ready && !redirect_valid;
    assign rsp_pkt   = '{pc: rsp_addr, instr: rsp_data};

    assign out_valid = (fifo_count != '0);

    // Addresses of issued requests, retired one per response (dropped or not)
    // because imem returns data strictly in order.
    fetch_fifo #(
        .T     (logic [XLEN-1:0]),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_fifo (
        .clk      (clk),
        .sync_rst (sync_rst),
        .flush    (1'b0),
        .push     (accept),
        .wr_data  (pc),
        .pop      (rsp_valid),
        .rd_data  (rsp_addr),
        .count    (addr_count)
    );

    // Packets waiting for downstream; cleared on redirect.
    fetch_fifo #(
        .T     (fetch_pkt_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk      (clk),
        .sync_rst (sync_rst),
        .flush    (redirect_valid),
        .push     (rsp_push),
        .wr_data  (rsp_pkt),
        .pop      (rsp_pop),
        .rd_data  (out_pkt),
        .count    (fifo_count)
    );

    // PC, outstanding-request and discard counters.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp_valid);
            if (redirect_valid) begin
                pc   <= align_word(redirect_pc);
                // Everything still in flight after this edge is stale; no
                // request issues during a redirect cycle.
                drop <= inflight - CW'(rsp_valid);
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    // The address FIFO and the inflight counter track the same population.
    a_addr_tracks_inflight: assert property (@(posedge clk) disable iff (sync_rst)
        addr_count == inflight);

    a_drop_le_inflight: assert property (@(posedge clk) disable iff (sync_rst)
        drop <= inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-1 imem model with an optional stall,
// in-order packet scoreboard, redirect, wrap-around and reset scenarios.
import rv32_pkg::*;

module tb_fetch_unit;

    logic        clk;
    logic        sync_rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    fetch_pkt_t  out_pkt;
    logic        out_ready;

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .out_valid      (out_valid),
        .out_pkt        (out_pkt),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    int          pops;
    int          accepts;
    logic [31:0] exp_pc;     // next pc the downstream should see
    logic [31:0] exp_req;    // next address the unit should issue
    logic [31:0] held;
    logic        mem_stall;
    logic        rst_seen;
    logic        found;
    logic [31:0] mem_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, then drive the imem
    // response for anything accepted at that edge.
    task automatic step();
        #1;
        if (!sync_rst && !redirect_valid && out_valid && out_ready) begin
            chk("pkt_pc", out_pkt.pc, exp_pc);
            chk("pkt_instr", out_pkt.instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (req_valid && req_ready) begin
            chk("req_addr_seq", req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            mem_q.push_back(req_addr);
            accepts++;
        end
        rst_seen = sync_rst;
        @(negedge clk);
        if (rst_seen) mem_q.delete();
        if (!mem_stall && mem_q.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = instr_of(mem_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        exp_pc   = 32'h0;
        exp_req  = 32'h0;
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; pops = 0; accepts = 0;
        exp_pc = 0; exp_req = 0; mem_stall = 0;
        sync_rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; out_ready = 1'b0;

        // Reset state
        steps(2);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pkt_pc", out_pkt.pc, 0);
        chk("rst_out_pkt_instr", out_pkt.instr, 0);
        sync_rst = 1'b0;
        #1;
        chk("post_rst_req_valid", req_valid, 1);
        chk("post_rst_req_addr", req_addr, 32'h0);

        // Free run: credit of 2 gives two packets every three cycles
        req_ready = 1'b1; out_ready = 1'b1; pops = 0;
        steps(12);
        chk("freerun_pops", pops, 7);

        // Downstream stall: only two requests fit, nothing lost
        do_reset();
        out_ready = 1'b0; accepts = 0;
        steps(10);
        chk("stall_accepts", accepts, 2);
        chk("stall_req_valid", req_valid, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_head_pc", out_pkt.pc, 32'h0);
        out_ready = 1'b1; pops = 0;
        steps(6);
        chk("stall_release_pops", pops >= 2, 1);

        // Redirect with two requests in flight: both responses discarded
        do_reset();
        mem_stall = 1'b1;
        steps(4);
        chk("inflight_full_req_valid", req_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req_valid", req_valid, 0);
        step();
        redirect_valid = 1'b0; mem_stall = 1'b0;
        exp_pc = 32'h100; exp_req = 32'h100;
        #1;
        chk("redir_req_addr", req_addr, 32'h100);
        pops = 0;
        steps(12);
        chk("redir_pops", pops >= 2, 1);

        // Redirect coincident with a live response
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin found = 1'b1; break; end
            step();
        end
        chk("rsp_seen_for_redirect", found, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        chk("redir2_req_valid", req_valid, 0);
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'h200; exp_req = 32'h200;
        #1;
        chk("redir2_out_valid", out_valid, 0);
        chk("redir2_req_addr", req_addr, 32'h200);
        pops = 0;
        steps(10);
        chk("redir2_pops", pops >= 2, 1);

        // PC wrap at the top of the address space (low bits forced to 0)
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'hFFFF_FFFC; exp_req = 32'hFFFF_FFFC;
        #1;
        chk("wrap_top_addr", req_addr, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_valid) begin found = 1'b1; break; end
            step();
        end
        chk("wrap_req_valid_seen", found, 1);
        step();
        chk("wrap_next_addr", req_addr, 32'h0);
        pops = 0;
        steps(8);
        chk("wrap_pops", pops >= 2, 1);

        // imem not ready: request held stable
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_valid) begin found = 1'b1; break; end
            step();
        end
        chk("hold_req_valid_seen", found, 1);
        req_ready = 1'b0;
        held = req_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_req_valid", req_valid, 1);
            chk("hold_req_addr", req_addr, held);
        end
        req_ready = 1'b1;
        steps(4);

        // Reset pulse mid-stream
        sync_rst = 1'b1;
        #1;
        chk("midrst_req_valid", req_valid, 0);
        step();
        sync_rst = 1'b0;
        exp_pc = 32'h0; exp_req = 32'h0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_addr", req_addr, 32'h0);
        chk("midrst_out_pkt_pc", out_pkt.pc, 32'h0);
        pops = 0;
        steps(6);
        chk("midrst_pops", pops >= 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
